// File: rtl/reg_file_2w.sv
// Two-read / two-write register file with hardwired zero register, optional
// write-to-read forwarding and a one-register-per-cycle clear sequencer.
//
// state   | meaning
// S_CLEAR | zeroing registers[idx], one per edge; reads return 0, writes dropped
// S_IDLE  | normal operation; ready=1
module reg_file_2w #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter bit ZERO_REG   = 1'b1,
   parameter bit BYPASS     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [ADDR_WIDTH-1:0] read_reg1,
   input  logic [ADDR_WIDTH-1:0] read_reg2,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2,
   input  logic [ADDR_WIDTH-1:0] write_reg1,
   input  logic [ADDR_WIDTH-1:0] write_reg2,
   input  logic [DATA_WIDTH-1:0] write_data1,
   input  logic [DATA_WIDTH-1:0] write_data2,
   input  logic                  reg_write1,
   input  logic                  reg_write2,
   output logic                  ready
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   idx, idx_nxt;
   logic [DATA_WIDTH-1:0]   regs [DEPTH];
   logic                    wr1_en, wr2_en;
   logic [ADDR_WIDTH-1:0]   rd_addr [2];
   logic [DATA_WIDTH-1:0]   rd_data [2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_CLEAR;
         idx   <= '0;
         ready <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         ready <= (state_nxt == S_IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         S_CLEAR: begin
            if (idx == IDX_LAST) begin
               state_nxt = S_IDLE;
               idx_nxt   = '0;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         S_IDLE: begin
            if (clear) begin
               state_nxt = S_CLEAR;
               idx_nxt   = '0;
            end
         end
         default: begin
            state_nxt = S_CLEAR;
            idx_nxt   = '0;
         end
      endcase
   end

   // clear on the same edge takes priority over both write ports
   assign wr1_en = (state == S_IDLE) && !clear && reg_write1 &&
                   !(ZERO_REG && (write_reg1 == '0));
   assign wr2_en = (state == S_IDLE) && !clear && reg_write2 &&
                   !(ZERO_REG && (write_reg2 == '0));

   // Storage has no reset; contents are defined by the clear sequence.
   always_ff @(posedge clk) begin
      if (state == S_CLEAR) begin
         regs[idx] <= '0;
      end else begin
         if (wr1_en) regs[write_reg1] <= write_data1;
         if (wr2_en) regs[write_reg2] <= write_data2;
      end
   end

   assign rd_addr[0] = read_reg1;
   assign rd_addr[1] = read_reg2;

   // port 2 forwarding is applied last so it wins over port 1
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = regs[rd_addr[p]];
         if (BYPASS) begin
            if (reg_write1 && (write_reg1 == rd_addr[p])) rd_data[p] = write_data1;
            if (reg_write2 && (write_reg2 == rd_addr[p])) rd_data[p] = write_data2;
         end
         if ((state != S_IDLE) || (ZERO_REG && (rd_addr[p] == '0))) rd_data[p] = '0;
      end
   end

   assign read_data1 = rd_data[0];
   assign read_data2 = rd_data[1];

endmodule

// File: tb/tb_reg_file_2w.sv
// Bench for reg_file_2w: a forwarding and a non-forwarding instance share all
// inputs and are checked against an array model with a clear countdown.
module tb_reg_file_2w;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst, clear, reg_write1, reg_write2;
   logic [AW-1:0] read_reg1, read_reg2, write_reg1, write_reg2;
   logic [DW-1:0] write_data1, write_data2;
   logic [DW-1:0] rd1_nb, rd2_nb, rd1_by, rd2_by;
   logic          ready_nb, ready_by;

   int            n_tests = 0;
   int            n_fail  = 0;

   logic [DW-1:0] mdl [DEPTH];
   int            clear_left;

   always #5 clk = ~clk;

   reg_file_2w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
      .clk(clk), .rst(rst), .clear(clear),
      .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(rd1_nb), .read_data2(rd2_nb),
      .write_reg1(write_reg1), .write_reg2(write_reg2),
      .write_data1(write_data1), .write_data2(write_data2),
      .reg_write1(reg_write1), .reg_write2(reg_write2),
      .ready(ready_nb)
   );

   reg_file_2w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut_by (
      .clk(clk), .rst(rst), .clear(clear),
      .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(rd1_by), .read_data2(rd2_by),
      .write_reg1(write_reg1), .write_reg2(write_reg2),
      .write_data1(write_data1), .write_data2(write_data2),
      .reg_write1(reg_write1), .reg_write2(reg_write2),
      .ready(ready_by)
   );

   // Expected combinational read for the current inputs and model state.
   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
      if (clear_left != 0 || a == '0) return '0;
      if (byp && reg_write2 && write_reg2 == a) return write_data2;
      if (byp && reg_write1 && write_reg1 == a) return write_data1;
      return mdl[a];
   endfunction

   // One rising edge: advance the model with the inputs seen at the edge.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         if (clear_left > 0) begin
            clear_left--;
         end else if (clear) begin
            clear_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
         end else begin
            if (reg_write1 && write_reg1 != '0) mdl[write_reg1] = write_data1;
            if (reg_write2 && write_reg2 != '0) mdl[write_reg2] = write_data2;
         end
      end
      #1;
   endtask

   task automatic idle_in();
      clear      = 1'b0;
      reg_write1 = 1'b0;
      reg_write2 = 1'b0;
   endtask

   task automatic test_reset();
      int cnt;
      rst = 1'b1;
      idle_in();
      read_reg1 = 5'd3; read_reg2 = 5'd17;
      write_reg1 = '0; write_reg2 = '0; write_data1 = '0; write_data2 = '0;
      clear_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      #2;
      n_tests++;
      if (ready_nb !== 1'b0 || ready_by !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready got %b/%b exp 0", ready_nb, ready_by);
      end
      n_tests++;
      if (rd1_by !== '0 || rd2_nb !== '0) begin
         n_fail++; $display("FAIL reset_rdata got %h/%h exp 0", rd1_by, rd2_nb);
      end
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      cnt = 0;
      while (cnt < 64) begin
         tick();
         cnt++;
         if (ready_nb === 1'b1) break;
         n_tests++;
         if (rd1_by !== '0 || rd2_by !== '0) begin
            n_fail++; $display("FAIL init_rdata edge %0d got %h/%h exp 0", cnt, rd1_by, rd2_by);
         end
      end
      n_tests++;
      if (cnt != DEPTH || ready_by !== 1'b1) begin
         n_fail++; $display("FAIL init_edges got %0d (ready_by %b) exp %0d", cnt, ready_by, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         read_reg1 = AW'(i); read_reg2 = AW'(DEPTH - 1 - i);
         #1;
         n_tests++;
         if (rd1_nb !== '0 || rd2_nb !== '0 || rd1_by !== '0 || rd2_by !== '0) begin
            n_fail++;
            $display("FAIL init_zero r%0d got %h %h %h %h exp 0", i, rd1_nb, rd2_nb, rd1_by, rd2_by);
         end
      end
   endtask

   task automatic test_basic();
      reg_write1 = 1'b1; write_reg1 = 5'd1;  write_data1 = 32'h0000FFFF;
      reg_write2 = 1'b1; write_reg2 = 5'd30; write_data2 = 32'hFFFF0000;
      tick();
      idle_in();
      read_reg1 = 5'd1; read_reg2 = 5'd30;
      #1;
      n_tests++;
      if (rd1_nb !== 32'h0000FFFF || rd2_nb !== 32'hFFFF0000) begin
         n_fail++; $display("FAIL basic_nb got %h %h exp 0000ffff ffff0000", rd1_nb, rd2_nb);
      end
      n_tests++;
      if (rd1_by !== 32'h0000FFFF || rd2_by !== 32'hFFFF0000) begin
         n_fail++; $display("FAIL basic_by got %h %h exp 0000ffff ffff0000", rd1_by, rd2_by);
      end
   endtask

   task automatic test_conflict_zero();
      reg_write1 = 1'b1; write_reg1 = 5'd5; write_data1 = 32'h11111111;
      reg_write2 = 1'b1; write_reg2 = 5'd5; write_data2 = 32'h22222222;
      tick();
      idle_in();
      read_reg1 = 5'd5; read_reg2 = 5'd5;
      #1;
      n_tests++;
      if (rd1_nb !== 32'h22222222 || rd2_by !== 32'h22222222) begin
         n_fail++; $display("FAIL conflict got %h %h exp 22222222", rd1_nb, rd2_by);
      end
      reg_write1 = 1'b1; write_reg1 = 5'd0; write_data1 = 32'hDEADBEEF;
      read_reg1 = 5'd0;
      #1;
      n_tests++;
      if (rd1_by !== '0) begin
         n_fail++; $display("FAIL zero_bypass got %h exp 0", rd1_by);
      end
      tick();
      idle_in();
      #1;
      n_tests++;
      if (rd1_nb !== '0 || rd1_by !== '0) begin
         n_fail++; $display("FAIL zero_reg got %h %h exp 0", rd1_nb, rd1_by);
      end
   endtask

   task automatic test_bypass();
      reg_write1 = 1'b1; write_reg1 = 5'd7; write_data1 = 32'hA5A5A5A5;
      read_reg1 = 5'd7; read_reg2 = 5'd7;
      #1;
      n_tests++;
      if (rd1_by !== 32'hA5A5A5A5 || rd2_by !== 32'hA5A5A5A5) begin
         n_fail++; $display("FAIL bypass_p1 got %h %h exp a5a5a5a5", rd1_by, rd2_by);
      end
      n_tests++;
      if (rd1_nb !== '0) begin
         n_fail++; $display("FAIL nobypass_old got %h exp 0", rd1_nb);
      end
      reg_write2 = 1'b1; write_reg2 = 5'd7; write_data2 = 32'h5A5A5A5A;
      #1;
      n_tests++;
      if (rd1_by !== 32'h5A5A5A5A) begin
         n_fail++; $display("FAIL bypass_prio got %h exp 5a5a5a5a", rd1_by);
      end
      tick();
      idle_in();
      #1;
      n_tests++;
      if (rd1_nb !== 32'h5A5A5A5A || rd2_by !== 32'h5A5A5A5A) begin
         n_fail++; $display("FAIL bypass_commit got %h %h exp 5a5a5a5a", rd1_nb, rd2_by);
      end
   endtask

   task automatic test_clear();
      for (int i = 1; i < DEPTH; i += 2) begin
         reg_write1 = 1'b1; write_reg1 = AW'(i);
         write_data1 = $urandom | 32'h1;
         reg_write2 = (i + 1 < DEPTH); write_reg2 = AW'((i + 1) % DEPTH);
         write_data2 = $urandom | 32'h1;
         tick();
      end
      idle_in();
      read_reg1 = 5'd9;
      #1;
      n_tests++;
      if (rd1_nb !== mdl[9] || rd1_nb === '0) begin
         n_fail++; $display("FAIL fill got %h exp %h", rd1_nb, mdl[9]);
      end
      clear = 1'b1;
      reg_write1 = 1'b1; write_reg1 = 5'd3; write_data1 = 32'h12345678;
      tick();
      idle_in();
      for (int k = 0; k < DEPTH; k++) begin
         read_reg1 = AW'($urandom_range(1, DEPTH - 1)); read_reg2 = 5'd3;
         #1;
         n_tests++;
         if (ready_nb !== 1'b0 || ready_by !== 1'b0 || rd1_nb !== '0 || rd2_by !== '0) begin
            n_fail++;
            $display("FAIL clear_busy k=%0d ready %b/%b rd %h %h exp 0", k, ready_nb, ready_by, rd1_nb, rd2_by);
         end
         tick();
      end
      n_tests++;
      if (ready_nb !== 1'b1 || ready_by !== 1'b1) begin
         n_fail++; $display("FAIL clear_ready got %b/%b exp 1", ready_nb, ready_by);
      end
      for (int i = 0; i < DEPTH; i++) begin
         read_reg1 = AW'(i); read_reg2 = AW'(i);
         #1;
         n_tests++;
         if (rd1_nb !== '0 || rd2_by !== '0) begin
            n_fail++; $display("FAIL clear_zero r%0d got %h %h exp 0", i, rd1_nb, rd2_by);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      int cnt;
      for (int i = 8; i < 16; i++) begin
         reg_write1 = 1'b1; write_reg1 = AW'(i); write_data1 = $urandom | 32'h100;
         tick();
      end
      idle_in();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (10) tick();
      #2 rst = 1'b1;
      clear_left = DEPTH;
      #1;
      n_tests++;
      if (ready_nb !== 1'b0 || ready_by !== 1'b0) begin
         n_fail++; $display("FAIL midrst_ready got %b/%b exp 0", ready_nb, ready_by);
      end
      repeat (2) tick();
      #2 rst = 1'b0;
      cnt = 0;
      while (cnt < 64) begin
         tick();
         cnt++;
         if (ready_nb === 1'b1) break;
      end
      n_tests++;
      if (cnt != DEPTH || ready_by !== 1'b1) begin
         n_fail++; $display("FAIL midrst_edges got %0d (ready_by %b) exp %0d", cnt, ready_by, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         read_reg1 = AW'(i); read_reg2 = AW'(DEPTH - 1 - i);
         #1;
         n_tests++;
         if (rd1_nb !== '0 || rd2_nb !== '0 || rd1_by !== '0) begin
            n_fail++; $display("FAIL midrst_zero r%0d got %h %h %h exp 0", i, rd1_nb, rd2_nb, rd1_by);
         end
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] e1n, e2n, e1b, e2b;
      for (int c = 0; c < 400; c++) begin
         reg_write1  = $urandom_range(0, 1);
         reg_write2  = $urandom_range(0, 1);
         write_reg1  = AW'($urandom_range(0, DEPTH - 1));
         write_reg2  = ($urandom_range(0, 3) == 0) ? write_reg1 : AW'($urandom_range(0, DEPTH - 1));
         write_data1 = $urandom;
         write_data2 = $urandom;
         clear       = ($urandom_range(0, 59) == 0);
         read_reg1   = ($urandom_range(0, 2) == 0) ? write_reg1 : AW'($urandom_range(0, DEPTH - 1));
         read_reg2   = ($urandom_range(0, 2) == 0) ? write_reg2 : AW'($urandom_range(0, DEPTH - 1));
         #1;
         e1n = exp_rd(read_reg1, 1'b0); e2n = exp_rd(read_reg2, 1'b0);
         e1b = exp_rd(read_reg1, 1'b1); e2b = exp_rd(read_reg2, 1'b1);
         n_tests++;
         if (rd1_nb !== e1n || rd2_nb !== e2n) begin
            n_fail++; $display("FAIL rand_nb c=%0d got %h %h exp %h %h", c, rd1_nb, rd2_nb, e1n, e2n);
         end
         n_tests++;
         if (rd1_by !== e1b || rd2_by !== e2b) begin
            n_fail++; $display("FAIL rand_by c=%0d got %h %h exp %h %h", c, rd1_by, rd2_by, e1b, e2b);
         end
         n_tests++;
         if (ready_nb !== (clear_left == 0) || ready_by !== (clear_left == 0)) begin
            n_fail++;
            $display("FAIL rand_ready c=%0d got %b/%b exp %b", c, ready_nb, ready_by, clear_left == 0);
         end
         tick();
      end
      idle_in();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_conflict_zero();
      test_bypass();
      test_clear();
      test_reset_mid_clear();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
